sram_stream_reader: RTL
=======================

# sram_stream_reader

Read-side initiator for the team's single-port `simple_sram` macro. It takes a burst request (base address, length), issues back-to-back SRAM reads through the active-low `csb`/`wsb` pins, and absorbs the SRAM's one-cycle read latency. It delivers the words as a valid/ready stream with a last marker. It sits between the SRAM buffers and the systolic-array feeders, which consume operand rows from it.

## Interface
- `DATA_WIDTH`, 32, SRAM word width
- `ADDR_WIDTH`, 10, SRAM address width
- `LEN_WIDTH`, 11, burst length counter width (max 1024 words)
- `clk` in 1: the only clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset
- `start` in 1: burst request, sampled only in IDLE
- `base_addr` in ADDR_WIDTH: first read address, latched on accepted `start`
- `length` in LEN_WIDTH: word count, latched on accepted `start`
- `stride` in ADDR_WIDTH: address increment. Present only with `SRAM_RD_STRIDE_EN`.
- `busy` out 1: high in RUN/DRAIN
- `done` out 1: one-cycle completion pulse
- `sram_csb` out 1: SRAM chip enable, active low
- `sram_wsb` out 1: SRAM write enable, constant 1
- `sram_raddr` out ADDR_WIDTH: SRAM read address
- `sram_rdata` in DATA_WIDTH: SRAM registered read data
- `out_valid` out 1, `out_ready` in 1: output handshake
- `out_data` out DATA_WIDTH, `out_last` out 1: stream payload and last-word flag

## Operation
- Reset values: `busy`=0, `done`=0, `sram_csb`=1, `sram_wsb`=1, `sram_raddr`=0, `out_valid`=0, `out_data`=0, `out_last`=0. Reset also sets state IDLE, empties the buffer, clears all counters, and drops any in-flight read.
- States:
  - **IDLE.** On `start` with `length`≠0, latch the request and go to RUN. On `start` with `length`=0, pulse `done` next cycle and stay in IDLE, with no SRAM access.
  - **RUN.** Issue one read per cycle while `issued < length` and `outstanding < 4`. On the cycle the final read issues, go to DRAIN.
  - **DRAIN.** When the word flagged `out_last` completes its handshake, go to IDLE and pulse `done`.
- `start` outside IDLE is ignored.
- `outstanding` counts reads issued but not yet popped. It increments on issue, decrements on an `out_valid & out_ready` handshake, and on a simultaneous issue and pop it is unchanged.
- A registered `rd_pending` flag marks the cycle in which `sram_rdata` is valid. The reader writes `sram_rdata` into a 4-entry FIFO on that edge.
- The FIFO can never overflow by construction of the credit rule. Simultaneous push and pop are allowed.
- Read address: word *i* reads from `base_addr + i*stride`, modulo 2^ADDR_WIDTH, so the address wraps silently. Without the macro, stride is 1.
- `out_last` is high with the word at index `length-1` only.
- Output order equals issue order. No word is dropped or duplicated under any `out_ready` pattern.

## Timing
- Edge E0 samples `start`.
  - Cycle 1: `sram_csb`=0 and `sram_raddr=base`.
  - Cycle 2: `sram_rdata` is valid and is captured at E2.
  - Cycle 3: `out_valid`=1. First-word latency is 3 cycles.
- With `out_ready` held high, throughput is 1 word/cycle and an N-word burst completes in N+2 cycles after `start`.
- `done` is high in the cycle after the final handshake, and `busy` falls in that same cycle.
- `out_valid`/`out_data`/`out_last` come from registers only; there is no combinational path from `sram_rdata`.
- Once `out_valid` is asserted, it and the payload stay stable until accepted.

## Configuration
- `SRAM_RD_STRIDE_EN` defined: the `stride` port exists and is latched on `start`, and the address advances by that latched stride. This supports column reads of row-major matrices.
- Undefined: there is no `stride` port and the address advances by 1.

## Structure
- The shared package holds the state enum (IDLE/RUN/DRAIN), the buffer depth constant `RD_BUF_DEPTH=4`, and the credit-counter width `$clog2(RD_BUF_DEPTH)+1`.
- One sub-module, `sram_rd_fifo`: 4-entry synchronous FIFO with push/pop/full/empty and registered head output.
- The FSM, address generator and credit counter stay in the top module.

## Test plan
- Preload mem[i]=i*0x11; `base`=0x010, `length`=4, `out_ready`=1. Expect `out_valid` from cycle 3 with data 0x110, 0x121, 0x132, 0x143, `out_last` on the 4th word, and `done` at cycle 7.
- Same burst with `length`=16, `out_ready` low for cycles 3–12, then high. Expect at most 4 `csb`-low cycles during the stall, then all 16 words in order with no loss.
- `base`=0x3FE, `length`=4. Expect `sram_raddr` 0x3FE, 0x3FF, 0x000, 0x001.
- `length`=0. Expect `done` pulse one cycle after `start`, `sram_csb` stays 1, and `out_valid` never asserts.
- Assert `rst` for 1 cycle after 2 of 8 words are delivered. Expect all outputs at reset values the next cycle. A new burst with `base`=0x020, `length`=2 then returns mem[0x20], mem[0x21] only.
- With `SRAM_RD_STRIDE_EN`: `base`=5, `stride`=32, `length`=3. Expect addresses 5, 37, 69 and matching data.

Source files
------------

// File: rtl/sram_stream_reader_pkg.sv
// Shared types and constants for the SRAM stream reader: FSM state encoding,
// read-buffer depth and the matching credit/pointer widths.
package sram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    localparam int RD_BUF_DEPTH = 4;
    localparam int CREDIT_WIDTH = $clog2(RD_BUF_DEPTH) + 1;
    localparam int RD_PTR_WIDTH = $clog2(RD_BUF_DEPTH);

endpackage

// File: rtl/sram_rd_fifo.sv
// Small synchronous FIFO that buffers SRAM read data for the stream reader.
// The head entry is held in its own register so the consumer sees flop outputs only.
module sram_rd_fifo
    import sram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0]        mem [RD_BUF_DEPTH];
    logic [RD_PTR_WIDTH-1:0] wr_ptr;
    logic [RD_PTR_WIDTH-1:0] rd_ptr;
    logic [RD_PTR_WIDTH-1:0] rd_ptr_nxt;
    logic [CREDIT_WIDTH-1:0] count;
    logic [WIDTH-1:0]        head_q;

    assign rd_ptr_nxt = rd_ptr + RD_PTR_WIDTH'(1);
    assign full       = (count == CREDIT_WIDTH'(RD_BUF_DEPTH));
    assign empty      = (count == '0);
    assign head_data  = head_q;

    // NOTE: storage is deliberately left without reset; the pointers and count
    // define which entries are meaningful, so resetting the array buys nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: every register in a clocked block is assigned with <= so all flops
    // update from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + RD_PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end

            case ({push, pop})
                2'b10:   count <= count + CREDIT_WIDTH'(1);
                2'b01:   count <= count - CREDIT_WIDTH'(1);
                default: count <= count;
            endcase

            // Head tracks the oldest entry; it is cleared when the FIFO drains.
            if (push && (empty || (count == CREDIT_WIDTH'(1) && pop))) begin
                head_q <= push_data;
            end else if (pop && count > CREDIT_WIDTH'(1)) begin
                head_q <= mem[rd_ptr_nxt];
            end else if (pop) begin
                head_q <= '0;
            end
        end
    end

endmodule

// File: rtl/sram_stream_reader.sv
// Burst reader for the single-port simple_sram: issues back-to-back reads,
// absorbs the one-cycle read latency and emits a valid/ready stream with last.
// Optional feature macro: SRAM_RD_STRIDE_EN adds a latched address stride.
module sram_stream_reader
    import sram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
`ifdef SRAM_RD_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] stride,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  sram_csb,
    output logic                  sram_wsb,
    output logic [ADDR_WIDTH-1:0] sram_raddr,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    rd_state_e               state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   addr_step;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    issued_q;
    logic [CREDIT_WIDTH-1:0] credit_q;
    logic                    rd_pending_q;
    logic                    rd_last_q;
    logic                    done_q, done_d;

    logic                    accept;
    logic                    issue;
    logic                    issue_last;
    logic                    pop;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DATA_WIDTH:0]     fifo_head;

`ifdef SRAM_RD_STRIDE_EN
    logic [ADDR_WIDTH-1:0]   stride_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q <= '0;
        end else if (accept && length != '0) begin
            stride_q <= stride;
        end
    end

    assign addr_step = stride_q;
`else
    assign addr_step = ADDR_WIDTH'(1);
`endif

    assign accept     = (state_q == ST_IDLE) && start;
    // The credit limit counts in-flight reads plus buffered words, so the
    // FIFO always has room for every read that has been issued.
    assign issue      = (state_q == ST_RUN) && (issued_q < len_q) &&
                        (credit_q < CREDIT_WIDTH'(RD_BUF_DEPTH));
    assign issue_last = issue && (issued_q == len_q - LEN_WIDTH'(1));
    assign pop        = out_valid && out_ready;

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign sram_csb   = ~issue;
    assign sram_wsb   = 1'b1;
    assign sram_raddr = addr_q;

    assign out_valid  = ~fifo_empty;
    assign out_data   = fifo_head[DATA_WIDTH-1:0];
    assign out_last   = fifo_head[DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // NOTE: defaults first, so every path through the case assigns both
    // outputs and no latch is inferred.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (issue_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && out_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
        end else if (accept && length != '0) begin
            addr_q   <= base_addr;
            len_q    <= length;
            issued_q <= '0;
        end else if (issue) begin
            addr_q   <= addr_q + addr_step;
            issued_q <= issued_q + LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   credit_q <= credit_q + CREDIT_WIDTH'(1);
                2'b01:   credit_q <= credit_q - CREDIT_WIDTH'(1);
                default: credit_q <= credit_q;
            endcase
        end
    end

    // rd_pending marks the cycle in which sram_rdata holds the read just issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending_q <= 1'b0;
            rd_last_q    <= 1'b0;
        end else begin
            rd_pending_q <= issue;
            rd_last_q    <= issue_last;
        end
    end

    sram_rd_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pending_q),
        .push_data ({rd_last_q, sram_rdata}),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (fifo_head)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_full && rd_pending_q && !pop));

endmodule
